mult_add_unit_float16: RTL and testbench

Streaming IEEE-754 half-precision multiply-accumulate unit for the CNN convolution datapath. Every clock it takes one operand pair and multiplies it. It sums the products of a group of `clk_num` consecutive pairs, presents the group sum with a one-cycle ready pulse, then starts the next group with no idle cycle.

---
 rtl/mult_add_unit_float16_pkg.sv | 41 ++++
 rtl/mult_add_unit_float16_if.sv | 15 +
 rtl/mult_add_unit_float16_fp16_add.sv | 83 ++++++++
 rtl/mult_add_unit_float16.sv | 112 +++++++++++
 tb/tb_mult_add_unit_float16.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/mult_add_unit_float16_pkg.sv
// Shared CNN datapath constants and FP16 helpers for the multiply-accumulate unit.
package mult_add_unit_float16_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int CLK_NUM_WIDTH = 8;
  localparam int SIGN_WIDTH    = 1;
  localparam int EXP_WIDTH     = 5;
  localparam int MANT_WIDTH    = 10;
  localparam int EXP_BIAS      = 15;

  localparam logic [DATA_WIDTH-1:0] FP16_POS_INF = 16'h7C00;
  localparam logic [DATA_WIDTH-1:0] FP16_NEG_INF = 16'hFC00;
  localparam logic [DATA_WIDTH-1:0] FP16_QNAN    = 16'h7E00;
  localparam logic [DATA_WIDTH-1:0] FP16_ZERO    = 16'h0000;

  typedef struct packed {
    logic [SIGN_WIDTH-1:0] sign;
    logic [EXP_WIDTH-1:0]  exp;
    logic [MANT_WIDTH-1:0] mant;
  } fp16_t;

  function automatic logic [DATA_WIDTH-1:0] fp16_inf(input logic s);
    return s ? FP16_NEG_INF : FP16_POS_INF;
  endfunction

  // RNE round of a normalized mantissa, then saturate to inf or flush to signed zero.
  function automatic logic [DATA_WIDTH-1:0] fp16_round_pack(input logic s,
                                                           input logic signed [7:0] e,
                                                           input logic [9:0] m,
                                                           input logic g,
                                                           input logic st);
    logic [10:0]       r;
    logic signed [7:0] e2;
    r  = {1'b0, m} + {10'b0, g & (st | m[0])};
    e2 = e + $signed({7'b0, r[10]});
    if (e2 >= 8'sd31)     return fp16_inf(s);
    else if (e2 <= 8'sd0) return {s, 15'b0};
    else                  return {s, e2[4:0], r[9:0]};
  endfunction

endpackage

// File: rtl/mult_add_unit_float16_if.sv
// Operand/result bundle of the FP16 multiply-accumulate unit.
interface mult_add_unit_float16_if;
  import mult_add_unit_float16_pkg::*;

  // No valid/ready pair: every clock edge out of reset consumes one (mult_a, mult_b)
  // pair, and result_ready is a one-cycle qualifier saying mult_add_result is a new group sum.
  logic [DATA_WIDTH-1:0]    mult_a;
  logic [DATA_WIDTH-1:0]    mult_b;
  logic [CLK_NUM_WIDTH-1:0] clk_num;
  logic                     result_ready;
  logic [DATA_WIDTH-1:0]    mult_add_result;

  modport master (output mult_a, mult_b, clk_num, input result_ready, mult_add_result);
  modport slave  (input mult_a, mult_b, clk_num, output result_ready, mult_add_result);
endinterface

// File: rtl/mult_add_unit_float16_fp16_add.sv
// Combinational FP16 adder: align, add/subtract, normalize, RNE round, specials, flush-to-zero.
module fp16_add
  import mult_add_unit_float16_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum
);

  fp16_t             fa, fb, x, y;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [4:0]        d;
  logic [13:0]       mx, my_full, my_sh, my, norm;
  logic              sticky;
  logic [14:0]       raw;
  logic [3:0]        lz;
  logic signed [7:0] e;

  function automatic logic [3:0] lzc14(input logic [13:0] v);
    logic [3:0] n;
    logic       found;
    n     = 4'd0;
    found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 4'd1;
      end
    end
    return n;
  endfunction

  assign fa = a;
  assign fb = b;

  always_comb begin
    a_zero = (fa.exp == '0);
    b_zero = (fb.exp == '0);
    a_inf  = (fa.exp == '1) && (fa.mant == '0);
    b_inf  = (fb.exp == '1) && (fb.mant == '0);
    a_nan  = (fa.exp == '1) && (fa.mant != '0);
    b_nan  = (fb.exp == '1) && (fb.mant != '0);

    // x carries the larger magnitude so the subtraction never goes negative.
    if ({fb.exp, fb.mant} > {fa.exp, fa.mant}) begin
      x = fb;
      y = fa;
    end else begin
      x = fa;
      y = fb;
    end
    d       = x.exp - y.exp;
    mx      = {1'b1, x.mant, 3'b000};
    my_full = {1'b1, y.mant, 3'b000};
    my_sh   = my_full >> d;
    sticky  = ((my_sh << d) != my_full);
    my      = my_sh | {13'b0, sticky};

    if (x.sign == y.sign) raw = {1'b0, mx} + {1'b0, my};
    else                  raw = {1'b0, mx} - {1'b0, my};

    e  = $signed({3'b000, x.exp});
    lz = lzc14(raw[13:0]);
    if (raw[14]) begin
      norm = raw[14:1] | {13'b0, raw[0]};
      e    = e + 8'sd1;
    end else begin
      norm = raw[13:0] << lz;
      e    = e - $signed({4'b0000, lz});
    end

    sum = fp16_round_pack(x.sign, e, norm[12:3], norm[2], |norm[1:0]);
    if (raw == '0) sum = FP16_ZERO;

    if (a_nan || b_nan || (a_inf && b_inf && (fa.sign != fb.sign))) sum = FP16_QNAN;
    else if (a_inf)             sum = fp16_inf(fa.sign);
    else if (b_inf)             sum = fp16_inf(fb.sign);
    else if (a_zero && b_zero)  sum = {fa.sign & fb.sign, 15'b0};
    else if (a_zero)            sum = b;
    else if (b_zero)            sum = a;
  end

endmodule

// File: rtl/mult_add_unit_float16.sv
// Streaming FP16 multiply-accumulate: sample pair, register rounded product, accumulate group.
module mult_add_unit_float16
  import mult_add_unit_float16_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  mult_add_unit_float16_if.slave io
);

  logic [DATA_WIDTH-1:0]    a_q, b_q, prod_q, acc_q, result_q;
  logic                     first1_q, last1_q, v1_q, first2_q, last2_q, v2_q, ready_q;
  logic [CLK_NUM_WIDTH-1:0] cnt_q, len_q, eff_len;
  logic                     first_pair, last_pair;

  fp16_t                    a_f, b_f;
  logic                     a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, prod_sign;
  logic [21:0]              prod_mant;
  logic signed [7:0]        prod_exp;
  logic [9:0]               prod_m;
  logic                     prod_g, prod_st;
  logic [DATA_WIDTH-1:0]    prod_d, sum_d, acc_d;

  // Group length is captured on the first pair; zero behaves as a group of one.
  always_comb begin
    first_pair = (cnt_q == '0);
    eff_len    = len_q;
    if (first_pair) eff_len = (io.clk_num == '0) ? CLK_NUM_WIDTH'(1) : io.clk_num;
    last_pair  = (CLK_NUM_WIDTH'(cnt_q + 1'b1) == eff_len);
  end

  assign a_f = a_q;
  assign b_f = b_q;

  always_comb begin
    a_zero    = (a_f.exp == '0);
    b_zero    = (b_f.exp == '0);
    a_inf     = (a_f.exp == '1) && (a_f.mant == '0);
    b_inf     = (b_f.exp == '1) && (b_f.mant == '0);
    a_nan     = (a_f.exp == '1) && (a_f.mant != '0);
    b_nan     = (b_f.exp == '1) && (b_f.mant != '0);
    prod_sign = a_f.sign ^ b_f.sign;
    prod_mant = {1'b1, a_f.mant} * {1'b1, b_f.mant};
    prod_exp  = $signed({3'b000, a_f.exp}) + $signed({3'b000, b_f.exp})
              - $signed(8'(EXP_BIAS)) + $signed({7'b0, prod_mant[21]});
    if (prod_mant[21]) begin
      prod_m  = prod_mant[20:11];
      prod_g  = prod_mant[10];
      prod_st = |prod_mant[9:0];
    end else begin
      prod_m  = prod_mant[19:10];
      prod_g  = prod_mant[9];
      prod_st = |prod_mant[8:0];
    end
    prod_d = fp16_round_pack(prod_sign, prod_exp, prod_m, prod_g, prod_st);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) prod_d = FP16_QNAN;
    else if (a_inf || b_inf)   prod_d = fp16_inf(prod_sign);
    else if (a_zero || b_zero) prod_d = {prod_sign, 15'b0};
  end

  fp16_add u_add (
    .a   (acc_q),
    .b   (prod_q),
    .sum (sum_d)
  );

  assign acc_d = first2_q ? prod_q : sum_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      b_q      <= '0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      v1_q     <= 1'b0;
      prod_q   <= '0;
      first2_q <= 1'b0;
      last2_q  <= 1'b0;
      v2_q     <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      cnt_q    <= '0;
      len_q    <= '0;
    end else begin
      a_q      <= io.mult_a;
      b_q      <= io.mult_b;
      first1_q <= first_pair;
      last1_q  <= last_pair;
      v1_q     <= 1'b1;
      len_q    <= eff_len;
      cnt_q    <= last_pair ? '0 : CLK_NUM_WIDTH'(cnt_q + 1'b1);

      prod_q   <= prod_d;
      first2_q <= first1_q;
      last2_q  <= last1_q;
      v2_q     <= v1_q;

      ready_q  <= 1'b0;
      if (v2_q) begin
        acc_q <= acc_d;
        if (last2_q) begin
          result_q <= acc_d;
          ready_q  <= 1'b1;
        end
      end
    end
  end

  assign io.result_ready    = ready_q;
  assign io.mult_add_result = result_q;

endmodule

// File: tb/tb_mult_add_unit_float16.sv
// Directed and small randomized stimulus for the FP16 multiply-accumulate unit.
module tb_mult_add_unit_float16;
  import mult_add_unit_float16_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  logic [DATA_WIDTH-1:0] exp_q[$];
  int                    cyc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_add_unit_float16_if io ();

  mult_add_unit_float16 dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Exact FP16 encoding of a small positive integer (1..2047).
  function automatic logic [15:0] int_to_fp16(input int v);
    int msb;
    int frac;
    msb = 0;
    for (int i = 0; i < 11; i++) if (((v >> i) & 1) == 1) msb = i;
    frac = (v << (10 - msb)) & 'h3FF;
    return {1'b0, 5'(msb + 15), 10'(frac)};
  endfunction

  // A group sum is expected three edges after the negedge that drives its last pair.
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [7:0] n,
                       input bit last, input logic [15:0] expv);
    @(negedge clk);
    io.mult_a  = a;
    io.mult_b  = b;
    io.clk_num = n;
    if (last) begin
      exp_q.push_back(expv);
      cyc_q.push_back(cyc + 3);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (io.result_ready) begin
        if (exp_q.size() == 0) begin
          check16("spurious_ready", {15'b0, io.result_ready}, 16'h0000);
        end else begin
          check16("group_sum", io.mult_add_result, exp_q.pop_front());
          check_int("ready_cycle", cyc, cyc_q.pop_front());
        end
      end else if (exp_q.size() > 0 && cyc_q[0] <= cyc) begin
        check16("missing_ready", {15'b0, io.result_ready}, 16'h0001);
        void'(exp_q.pop_front());
        void'(cyc_q.pop_front());
      end
    end
  end

  initial begin
    int n, x, y, s;
    io.mult_a  = '0;
    io.mult_b  = '0;
    io.clk_num = '0;

    repeat (2) @(posedge clk);
    #1;
    check16("reset_result", io.mult_add_result, 16'h0000);
    check16("reset_ready", {15'b0, io.result_ready}, 16'h0000);
    @(posedge clk);
    #2 rst = 1'b1;

    // Group of four: 2 + 4 + 6 + 2 = 14.
    drive(16'h3C00, 16'h4000, 8'd4, 0, 16'h0);
    drive(16'h4000, 16'h4000, 8'd4, 0, 16'h0);
    drive(16'h4000, 16'h4200, 8'd4, 0, 16'h0);
    drive(16'h3C00, 16'h4000, 8'd4, 1, 16'h4B00);
    // Back-to-back group of two: 2 + 4 = 6.
    drive(16'h3C00, 16'h4000, 8'd2, 0, 16'h0);
    drive(16'h4000, 16'h4000, 8'd2, 1, 16'h4600);
    // Length one, then length zero acting as one.
    repeat (3) drive(16'h4000, 16'h4200, 8'd1, 1, 16'h4600);
    repeat (3) drive(16'h4000, 16'h4200, 8'd0, 1, 16'h4600);

    // Specials.
    drive(16'h7BFF, 16'h4000, 8'd2, 0, 16'h0);
    drive(16'h0000, 16'h0000, 8'd2, 1, 16'h7C00);
    drive(16'hBC00, 16'h4000, 8'd2, 0, 16'h0);
    drive(16'h4000, 16'h3C00, 8'd2, 1, 16'h0000);
    drive(16'h7E00, 16'h3C00, 8'd2, 0, 16'h0);
    drive(16'h3C00, 16'h3C00, 8'd2, 1, 16'h7E00);
    drive(16'h0001, 16'h3C00, 8'd2, 0, 16'h0);
    drive(16'h3C00, 16'h3C00, 8'd2, 1, 16'h3C00);

    // Rounding: 1 + 2^-11 is a tie to even (3C00); 1 + 2^-10 is exact (3C01);
    // (1 + 2^-10) + 2^-11 is a tie rounding up to even (3C02).
    drive(16'h3C00, 16'h3C00, 8'd2, 0, 16'h0);
    drive(16'h1000, 16'h3C00, 8'd2, 1, 16'h3C00);
    drive(16'h3C00, 16'h3C00, 8'd2, 0, 16'h0);
    drive(16'h1400, 16'h3C00, 8'd2, 1, 16'h3C01);
    drive(16'h3C01, 16'h3C00, 8'd2, 0, 16'h0);
    drive(16'h1000, 16'h3C00, 8'd2, 1, 16'h3C02);

    // Random small-integer groups, all sums exactly representable.
    for (int g = 0; g < 6; g++) begin
      n = $urandom_range(1, 4);
      s = 0;
      for (int i = 0; i < n; i++) begin
        x = $urandom_range(1, 8);
        y = $urandom_range(1, 4);
        s += x * y;
        drive(int_to_fp16(x), int_to_fp16(y), 8'(n), (i == n - 1), int_to_fp16(s));
      end
    end

    // Reset mid-group after two pairs; the partial sum must not leak.
    drive(16'h4000, 16'h4000, 8'd4, 0, 16'h0);
    drive(16'h4000, 16'h4000, 8'd4, 0, 16'h0);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check16("midreset_result", io.mult_add_result, 16'h0000);
    check16("midreset_ready", {15'b0, io.result_ready}, 16'h0000);
    @(posedge clk);
    #2 rst = 1'b1;
    drive(16'h3C00, 16'h3C00, 8'd4, 0, 16'h0);
    drive(16'h3C00, 16'h3C00, 8'd4, 0, 16'h0);
    drive(16'h3C00, 16'h3C00, 8'd4, 0, 16'h0);
    drive(16'h3C00, 16'h3C00, 8'd4, 1, 16'h4400);

    // An incomplete trailing group keeps the stream fed without producing a result.
    drive(16'h3C00, 16'h3C00, 8'd4, 0, 16'h0);
    drive(16'h3C00, 16'h3C00, 8'd4, 0, 16'h0);
    drive(16'h3C00, 16'h3C00, 8'd4, 0, 16'h0);
    repeat (2) @(negedge clk);
    #1;
    check_int("pending_results", exp_q.size(), 0);
    check16("final_ready", {15'b0, io.result_ready}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
